// File: rtl/alu_mem_sequencer_pkg.sv
// Shared definitions for the ALU/memory sequencer: FSM encodings, address selects, ALU opcodes.
// Optional build macro: ALU_SEQ_OVF_TRAP_EN (overflow skips write-back and raises ovf_trap).
package alu_mem_sequencer_pkg;

    localparam int WORDSIZE_DEF = 8;
    localparam int ADDR_W_DEF   = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_CAP_B = 3'd3,
        ST_EXEC  = 3'd4,
        ST_WR    = 3'd5,
        ST_DONE  = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_B    = 2'd2,
        SEL_D    = 2'd3
    } addr_sel_e;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_RSB   = 4'd2;
    localparam logic [3:0] OP_MUL4H = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_NAND  = 4'd6;
    localparam logic [3:0] OP_XNOR  = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SLL   = 4'd9;
    localparam logic [3:0] OP_ROR   = 4'd10;
    localparam logic [3:0] OP_ROL   = 4'd11;
    localparam logic [3:0] OP_NOP   = 4'd12;

endpackage

// File: rtl/alu_mem_sequencer_if.sv
// Host command, MEM and ALU signals of the sequencer; master = sequencer view, slave = environment.
// Optional build macro: ALU_SEQ_OVF_TRAP_EN adds o_ovf_trap.
interface alu_mem_sequencer_if #(
    parameter int WORDSIZE = 8,
    parameter int ADDR_W   = 9
);
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [3:0]          i_cmd_op;
    logic [ADDR_W-1:0]   i_cmd_addr_a;
    logic [ADDR_W-1:0]   i_cmd_addr_b;
    logic [ADDR_W-1:0]   i_cmd_addr_d;
    logic                o_done;
    logic [WORDSIZE-1:0] o_result;
    logic                o_result_ovf;
    logic                o_mem_Enable;
    logic                o_mem_WE;
    logic                o_mem_RE;
    logic [ADDR_W-1:0]   o_mem_address;
    logic [WORDSIZE-1:0] o_mem_data_in;
    logic [WORDSIZE-1:0] i_mem_data_out;
    logic [WORDSIZE-1:0] o_alu_ain;
    logic [WORDSIZE-1:0] o_alu_bin;
    logic [3:0]          o_alu_ctrl;
    logic [WORDSIZE-1:0] i_alu_zout;
    logic                i_alu_overflow;
`ifdef ALU_SEQ_OVF_TRAP_EN
    logic                o_ovf_trap;
`endif

    modport master (
        input  i_cmd_valid, i_cmd_op, i_cmd_addr_a, i_cmd_addr_b, i_cmd_addr_d,
        input  i_mem_data_out, i_alu_zout, i_alu_overflow,
`ifdef ALU_SEQ_OVF_TRAP_EN
        output o_ovf_trap,
`endif
        output o_cmd_ready, o_done, o_result, o_result_ovf,
        output o_mem_Enable, o_mem_WE, o_mem_RE, o_mem_address, o_mem_data_in,
        output o_alu_ain, o_alu_bin, o_alu_ctrl
    );

    modport slave (
        output i_cmd_valid, i_cmd_op, i_cmd_addr_a, i_cmd_addr_b, i_cmd_addr_d,
        output i_mem_data_out, i_alu_zout, i_alu_overflow,
`ifdef ALU_SEQ_OVF_TRAP_EN
        input  o_ovf_trap,
`endif
        input  o_cmd_ready, o_done, o_result, o_result_ovf,
        input  o_mem_Enable, o_mem_WE, o_mem_RE, o_mem_address, o_mem_data_in,
        input  o_alu_ain, o_alu_bin, o_alu_ctrl
    );

endinterface

// File: rtl/alu_seq_fsm.sv
// Sequencer FSM: every strobe is registered from the transition, so it is glitch-free in its state.
// Optional build macro: ALU_SEQ_OVF_TRAP_EN (EXEC with overflow jumps straight to DONE).
module alu_seq_fsm
    import alu_mem_sequencer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_cmd_valid,
`ifdef ALU_SEQ_OVF_TRAP_EN
    input  logic      i_alu_overflow,
    output logic      o_ovf_trap,
`endif
    output logic      o_cmd_ready,
    output logic      o_mem_en,
    output logic      o_mem_we,
    output logic      o_mem_re,
    output addr_sel_e o_addr_sel,
    output logic      o_cap_a,
    output logic      o_cap_b,
    output logic      o_exec,
    output logic      o_done
);

    seq_state_e r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            o_cmd_ready <= 1'b1;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_addr_sel  <= SEL_NONE;
            o_cap_a     <= 1'b0;
            o_cap_b     <= 1'b0;
            o_exec      <= 1'b0;
            o_done      <= 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
            o_ovf_trap  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (i_cmd_valid) begin
                    r_state     <= ST_RD_A;
                    o_cmd_ready <= 1'b0;
                    o_mem_en    <= 1'b1;
                    o_mem_re    <= 1'b1;
                    o_addr_sel  <= SEL_A;
                end
                ST_RD_A: begin
                    r_state    <= ST_RD_B;
                    o_addr_sel <= SEL_B;
                    o_cap_a    <= 1'b1;
                end
                ST_RD_B: begin
                    r_state    <= ST_CAP_B;
                    o_mem_en   <= 1'b0;
                    o_mem_re   <= 1'b0;
                    o_addr_sel <= SEL_NONE;
                    o_cap_a    <= 1'b0;
                    o_cap_b    <= 1'b1;
                end
                ST_CAP_B: begin
                    r_state <= ST_EXEC;
                    o_cap_b <= 1'b0;
                    o_exec  <= 1'b1;
                end
                ST_EXEC: begin
                    o_exec <= 1'b0;
`ifdef ALU_SEQ_OVF_TRAP_EN
                    if (i_alu_overflow) begin
                        r_state    <= ST_DONE;
                        o_done     <= 1'b1;
                        o_ovf_trap <= 1'b1;
                    end else begin
                        r_state    <= ST_WR;
                        o_mem_en   <= 1'b1;
                        o_mem_we   <= 1'b1;
                        o_addr_sel <= SEL_D;
                    end
`else
                    r_state    <= ST_WR;
                    o_mem_en   <= 1'b1;
                    o_mem_we   <= 1'b1;
                    o_addr_sel <= SEL_D;
`endif
                end
                ST_WR: begin
                    r_state    <= ST_DONE;
                    o_mem_en   <= 1'b0;
                    o_mem_we   <= 1'b0;
                    o_addr_sel <= SEL_NONE;
                    o_done     <= 1'b1;
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    o_done      <= 1'b0;
                    o_cmd_ready <= 1'b1;
`ifdef ALU_SEQ_OVF_TRAP_EN
                    o_ovf_trap  <= 1'b0;
`endif
                end
                default: begin
                    r_state     <= ST_IDLE;
                    o_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_mem_sequencer.sv
// Sequences one ALU op on memory operands: read A, read B, execute, write back, pulse done.
// Optional build macro: ALU_SEQ_OVF_TRAP_EN (overflow suppresses write-back, pulses ovf_trap).
module alu_mem_sequencer
    import alu_mem_sequencer_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    alu_mem_sequencer_if.master bus
);

    logic [3:0]          r_op;
    logic [ADDR_W-1:0]   r_addr_a, r_addr_b, r_addr_d;
    logic [WORDSIZE-1:0] r_alu_ain, r_alu_bin, r_result;
    logic [3:0]          r_alu_ctrl;
    logic                r_ovf;

    logic                w_ready, w_mem_en, w_mem_we, w_mem_re;
    logic                w_cap_a, w_cap_b, w_exec, w_done, w_accept;
    addr_sel_e           w_sel;
    logic [ADDR_W-1:0]   w_addr;

    alu_seq_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_valid    (bus.i_cmd_valid),
`ifdef ALU_SEQ_OVF_TRAP_EN
        .i_alu_overflow (bus.i_alu_overflow),
        .o_ovf_trap     (bus.o_ovf_trap),
`endif
        .o_cmd_ready    (w_ready),
        .o_mem_en       (w_mem_en),
        .o_mem_we       (w_mem_we),
        .o_mem_re       (w_mem_re),
        .o_addr_sel     (w_sel),
        .o_cap_a        (w_cap_a),
        .o_cap_b        (w_cap_b),
        .o_exec         (w_exec),
        .o_done         (w_done)
    );

    assign w_accept = bus.i_cmd_valid & w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_addr_d   <= '0;
            r_alu_ain  <= '0;
            r_alu_bin  <= '0;
            r_alu_ctrl <= '0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.i_cmd_op;
                r_addr_a <= bus.i_cmd_addr_a;
                r_addr_b <= bus.i_cmd_addr_b;
                r_addr_d <= bus.i_cmd_addr_d;
            end
            // MEM read data lags the address by one cycle, so A lands at the end of RD_B.
            if (w_cap_a) begin
                r_alu_ain  <= bus.i_mem_data_out;
                r_alu_ctrl <= r_op;
            end
            if (w_cap_b) r_alu_bin <= bus.i_mem_data_out;
            if (w_exec) begin
                r_result <= bus.i_alu_zout;
                r_ovf    <= bus.i_alu_overflow;
            end
        end
    end

    always_comb begin
        w_addr = '0;
        case (w_sel)
            SEL_A:   w_addr = r_addr_a;
            SEL_B:   w_addr = r_addr_b;
            SEL_D:   w_addr = r_addr_d;
            default: w_addr = '0;
        endcase
    end

    assign bus.o_cmd_ready   = w_ready;
    assign bus.o_done        = w_done;
    assign bus.o_result      = r_result;
    assign bus.o_result_ovf  = r_ovf;
    assign bus.o_mem_Enable  = w_mem_en;
    assign bus.o_mem_WE      = w_mem_we;
    assign bus.o_mem_RE      = w_mem_re;
    assign bus.o_mem_address = w_addr;
    assign bus.o_mem_data_in = r_result;
    assign bus.o_alu_ain     = r_alu_ain;
    assign bus.o_alu_bin     = r_alu_bin;
    assign bus.o_alu_ctrl    = r_alu_ctrl;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Directed bench for alu_mem_sequencer with a registered-read MEM model and a small ALU model.
// Honours ALU_SEQ_OVF_TRAP_EN when the design is built with it.
module tb_alu_mem_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mem_sequencer_if bus ();

    alu_mem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_viol = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Environment: MEM with registered read, plus a preload port for the bench
    logic [7:0] mem [0:511];
    logic [7:0] mem_dout = 8'h00;
    logic       pl_en = 1'b0;
    logic [8:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.o_mem_Enable && bus.o_mem_WE) mem[bus.o_mem_address] <= bus.o_mem_data_in;
        if (bus.o_mem_Enable && bus.o_mem_RE) mem_dout <= mem[bus.o_mem_address];
    end
    assign bus.i_mem_data_out = mem_dout;

    logic [8:0] alu_z9;
    always_comb begin
        alu_z9 = '0;
        case (bus.o_alu_ctrl)
            4'd0:    alu_z9 = {1'b0, bus.o_alu_ain} + {1'b0, bus.o_alu_bin};
            4'd1:    alu_z9 = {1'b0, bus.o_alu_ain} - {1'b0, bus.o_alu_bin};
            4'd4:    alu_z9 = {1'b0, ~(bus.o_alu_ain | bus.o_alu_bin)};
            4'd6:    alu_z9 = {1'b0, ~(bus.o_alu_ain & bus.o_alu_bin)};
            4'd7:    alu_z9 = {1'b0, ~(bus.o_alu_ain ^ bus.o_alu_bin)};
            default: alu_z9 = {1'b0, bus.o_alu_ain};
        endcase
    end
    assign bus.i_alu_zout     = alu_z9[7:0];
    assign bus.i_alu_overflow = alu_z9[8];

    always @(negedge clk) if (bus.o_mem_RE && bus.o_mem_WE) n_viol++;

    task automatic mem_wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] d);
        bus.i_cmd_op = op; bus.i_cmd_addr_a = a; bus.i_cmd_addr_b = b; bus.i_cmd_addr_d = d;
    endtask

    // Issue one command; lat = cycle index (1 = first cycle after accept) in which done is high
    task automatic run_cmd(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                           input logic [8:0] d, output int lat, output logic trap);
        lat = -1; trap = 1'b0;
        @(negedge clk);
        set_cmd(op, a, b, d);
        bus.i_cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.o_cmd_ready; k++) @(negedge clk);
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                lat = n;
`ifdef ALU_SEQ_OVF_TRAP_EN
                trap = bus.o_ovf_trap;
`endif
                break;
            end
        end
    endtask

    int   lat, dones, t1, t2, acc2;
    logic trap;
    logic seen;

    initial begin
        bus.i_cmd_valid = 1'b0;
        set_cmd(4'd0, 9'd0, 9'd0, 9'd0);

        @(negedge clk);
        chk("rst_ready", bus.o_cmd_ready, 1);
        chk("rst_done", bus.o_done, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_ovf", bus.o_result_ovf, 0);
        chk("rst_memctl", {bus.o_mem_Enable, bus.o_mem_WE, bus.o_mem_RE}, 0);
        chk("rst_addr", bus.o_mem_address, 0);
        chk("rst_alu", {bus.o_alu_ain, bus.o_alu_bin, 4'(bus.o_alu_ctrl)}, 0);
        rst = 1'b0;

        // Plain add
        mem_wr(9'd0, 8'h12); mem_wr(9'd1, 8'h34); mem_wr(9'd2, 8'h00);
        run_cmd(4'd0, 9'd0, 9'd1, 9'd2, lat, trap);
        chk("add_lat", lat, 6);
        chk("add_result", bus.o_result, 8'h46);
        chk("add_ovf", bus.o_result_ovf, 0);
        @(negedge clk);
        chk("add_mem", mem[2], 8'h46);

        // Overflowing add
        mem_wr(9'd0, 8'hF0); mem_wr(9'd1, 8'h20); mem_wr(9'd3, 8'hAA);
        run_cmd(4'd0, 9'd0, 9'd1, 9'd3, lat, trap);
        chk("ovf_result", bus.o_result, 8'h10);
        chk("ovf_flag", bus.o_result_ovf, 1);
        @(negedge clk);
`ifdef ALU_SEQ_OVF_TRAP_EN
        chk("ovf_lat", lat, 5);
        chk("ovf_trap", trap, 1);
        chk("ovf_mem", mem[3], 8'hAA);
`else
        chk("ovf_lat", lat, 6);
        chk("ovf_mem", mem[3], 8'h10);
`endif

        // A = B = D aliasing
        mem_wr(9'd5, 8'h0F);
        run_cmd(4'd6, 9'd5, 9'd5, 9'd5, lat, trap);
        chk("alias_result", bus.o_result, 8'hF0);
        @(negedge clk);
        chk("alias_mem", mem[5], 8'hF0);

        // cmd_valid while busy is ignored
        mem_wr(9'd8, 8'h50); mem_wr(9'd9, 8'h20); mem_wr(9'd10, 8'h00); mem_wr(9'd11, 8'h55);
        @(negedge clk);
        set_cmd(4'd1, 9'd8, 9'd9, 9'd10);
        bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (bus.o_done) dones++;
            if (n >= 2 && n <= 5) begin
                chk($sformatf("busy_ready_c%0d", n), bus.o_cmd_ready, 0);
                set_cmd(4'd0, 9'd8, 9'd9, 9'd11);
                bus.i_cmd_valid = 1'b1;
            end else begin
                bus.i_cmd_valid = 1'b0;
            end
        end
        chk("busy_dones", dones, 1);
        chk("busy_mem_d", mem[10], 8'h30);
        chk("busy_mem_other", mem[11], 8'h55);

        // Reset during WR
        mem_wr(9'd0, 8'h12); mem_wr(9'd1, 8'h34); mem_wr(9'd12, 8'h77);
        @(negedge clk);
        set_cmd(4'd0, 9'd0, 9'd1, 9'd12);
        bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_mem_WE) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstwr_we_seen", seen, 1);
        rst = 1'b1;
        #1;
        chk("rstwr_we", bus.o_mem_WE, 0);
        chk("rstwr_en", bus.o_mem_Enable, 0);
        chk("rstwr_ready", bus.o_cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwr_mem", mem[12], 8'h77);
        chk("rstwr_result", bus.o_result, 0);

        // Back-to-back commands with cmd_valid held
        mem_wr(9'd20, 8'h09); mem_wr(9'd21, 8'h03); mem_wr(9'd22, 8'hEE);
        mem_wr(9'd23, 8'h0F); mem_wr(9'd24, 8'hF0); mem_wr(9'd25, 8'hEE);
        @(negedge clk);
        set_cmd(4'd1, 9'd20, 9'd21, 9'd22);
        bus.i_cmd_valid = 1'b1;
        @(posedge clk);
        #1 set_cmd(4'd4, 9'd23, 9'd24, 9'd25);
        t1 = -1; t2 = -1; acc2 = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (acc2 > 0 && n == acc2 + 1) bus.i_cmd_valid = 1'b0;
            if (acc2 < 0 && bus.o_cmd_ready) acc2 = n;
        end
        bus.i_cmd_valid = 1'b0;
        chk("b2b_t1", t1, 6);
        chk("b2b_accept2", acc2, 7);
        chk("b2b_gap", t2 - t1, 7);
        chk("b2b_mem1", mem[22], 8'h06);
        chk("b2b_mem2", mem[25], 8'h00);

        chk("re_we_exclusive", n_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
